// File: rtl/booth_pp_accumulator_if.sv
// Valid/ready bundle between the Booth row multiplexer, the partial-product
// accumulator and the exponent-align stage.
interface booth_pp_accumulator_if #(
    parameter int PP_W   = 14,
    parameter int PROD_W = 22
);
    logic              pp_valid;
    logic              pp_ready;
    logic [PP_W-1:0]   pp_data;
    logic              pp_neg;
    logic              pp_last;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              err;

    modport master (
        output pp_valid, pp_data, pp_neg, pp_last, prod_ready,
        input  pp_ready, prod_valid, prod_data, err
    );

    modport slave (
        input  pp_valid, pp_data, pp_neg, pp_last, prod_ready,
        output pp_ready, prod_valid, prod_data, err
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Accumulates four radix-8 Booth partial products (one per beat) into the
// unsigned 22-bit mantissa product, with a sticky protocol/overflow error.
module booth_pp_accumulator #(
    parameter int NUM_PP = 4,
    parameter int PP_W   = 14,
    parameter int PROD_W = 22,
    parameter int ACC_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_pp_accumulator_if.slave  bus
);
    localparam int               IDX_W    = $clog2(NUM_PP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - 1);

    typedef enum logic {COLLECT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  acc_next;
    logic [PROD_W-1:0]        prod_q, prod_d;
    logic                     pvld_q, pvld_d;
    logic                     err_q, err_d;

    // Sign-extend the beat, add the one's-complement correction, then apply
    // the radix-8 weight 2^(3*idx).
    function automatic logic signed [ACC_W-1:0] weighted_pp(
        input logic [PP_W-1:0]  d,
        input logic             neg,
        input logic [IDX_W-1:0] idx
    );
        logic signed [ACC_W-1:0] v;
        v = signed'({{(ACC_W-PP_W){d[PP_W-1]}}, d})
          + signed'({{(ACC_W-1){1'b0}}, neg});
        return v <<< (3 * idx);
    endfunction

    assign acc_next = acc_q + weighted_pp(bus.pp_data, bus.pp_neg, idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        pvld_d  = pvld_q;
        err_d   = err_q;
        unique case (state_q)
            COLLECT: begin
                if (bus.pp_valid) begin
                    acc_d = acc_next;
                    idx_d = idx_q + 1'b1;
                    if (bus.pp_last != (idx_q == LAST_IDX)) err_d = 1'b1;
                    // Completion is decided by the beat count alone.
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                        prod_d  = acc_next[PROD_W-1:0];
                        pvld_d  = 1'b1;
                        if (acc_next[ACC_W-1:PROD_W] != '0) err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.prod_ready) begin
                    pvld_d  = 1'b0;
                    acc_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            pvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            pvld_q  <= pvld_d;
            err_q   <= err_d;
        end
    end

    assign bus.pp_ready   = (state_q == COLLECT);
    assign bus.prod_valid = pvld_q;
    assign bus.prod_data  = prod_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: hand-computed Booth beat vectors
// with immediate-assertion checks.
module tb_booth_pp_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    booth_pp_accumulator_if bus ();

    booth_pp_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input logic [13:0] d, input logic n, input logic l);
        int cyc;
        cyc = 0;
        bus.pp_valid = 1'b1;
        bus.pp_data  = d;
        bus.pp_neg   = n;
        bus.pp_last  = l;
        while (!bus.pp_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!bus.pp_ready) begin
            checks++;
            failures++;
            $error("FAIL beat_timeout observed=%0d expected=%0d", cyc, 20);
        end else begin
            tick();
        end
    endtask

    task automatic idle();
        bus.pp_valid = 1'b0;
        tick();
    endtask

    initial begin
        bus.pp_valid   = 1'b1;
        bus.pp_data    = 14'h1234;
        bus.pp_neg     = 1'b0;
        bus.pp_last    = 1'b0;
        bus.prod_ready = 1'b1;

        // Reset state, with a beat offered during reset
        tick(); tick();
        chk("rst_pp_ready", 32'(bus.pp_ready), 1);
        chk("rst_prod_valid", 32'(bus.prod_valid), 0);
        chk("rst_prod_data", 32'(bus.prod_data), 0);
        chk("rst_err", 32'(bus.err), 0);
        bus.pp_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 2047 x 2047 back-to-back: -2047 + 8188*512 = 4190209
        send_beat(14'h3800, 1'b1, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd8188, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("full_prod_valid", 32'(bus.prod_valid), 1);
        chk("full_prod_data", 32'(bus.prod_data), 4190209);
        chk("full_err", 32'(bus.err), 0);
        chk("full_done_pp_ready", 32'(bus.pp_ready), 0);
        tick();
        chk("full_drain_prod_valid", 32'(bus.prod_valid), 0);
        chk("full_drain_pp_ready", 32'(bus.pp_ready), 1);

        // 1024 x 1024: 2048*512 = 1048576
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd2048, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("p1024_prod_data", 32'(bus.prod_data), 1048576);
        tick();

        // Same with beat 1 as negative zero
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'h3FFF, 1'b1, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd2048, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("negzero_prod_data", 32'(bus.prod_data), 1048576);
        chk("negzero_err", 32'(bus.err), 0);
        tick();

        // Backpressure: 5 + 2*8 = 21, then extra beats must be held off
        bus.prod_ready = 1'b0;
        send_beat(14'd5, 1'b0, 1'b0);
        send_beat(14'd2, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b1);
        bus.pp_valid = 1'b1;
        bus.pp_data  = 14'd7;
        bus.pp_neg   = 1'b0;
        bus.pp_last  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_prod_valid", 32'(bus.prod_valid), 1);
            chk("bp_prod_data", 32'(bus.prod_data), 21);
            chk("bp_pp_ready", 32'(bus.pp_ready), 0);
            tick();
        end
        bus.prod_ready = 1'b1;
        tick();
        chk("bp_release_prod_valid", 32'(bus.prod_valid), 0);
        chk("bp_release_pp_ready", 32'(bus.pp_ready), 1);
        // Next multiply: 7 + 1*512 = 519, acc must start from zero
        send_beat(14'd7, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd1, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("bp_next_prod_data", 32'(bus.prod_data), 519);
        tick();

        // Bubbles: valid pattern 1,0,0,1,1,0,1
        send_beat(14'h3800, 1'b1, 1'b0);
        idle();
        idle();
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        idle();
        send_beat(14'd8188, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("bubble_prod_valid", 32'(bus.prod_valid), 1);
        chk("bubble_prod_data", 32'(bus.prod_data), 4190209);
        chk("bubble_err", 32'(bus.err), 0);
        tick();

        // Protocol error: last flagged on beat 2; product 1 still emitted
        send_beat(14'd1, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b1);
        chk("proto_err_set", 32'(bus.err), 1);
        chk("proto_no_early_done", 32'(bus.pp_ready), 1);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("proto_prod_valid", 32'(bus.prod_valid), 1);
        chk("proto_prod_data", 32'(bus.prod_data), 1);
        tick();
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd2048, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("proto_clean_prod_data", 32'(bus.prod_data), 1048576);
        chk("proto_err_sticky", 32'(bus.err), 1);
        tick();

        // Reset mid-multiply after 2 beats (previous product 1048576 pending in reg)
        send_beat(14'd100, 1'b0, 1'b0);
        send_beat(14'd3, 1'b0, 1'b0);
        bus.pp_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_pp_ready", 32'(bus.pp_ready), 1);
        chk("midrst_prod_valid", 32'(bus.prod_valid), 0);
        chk("midrst_prod_data", 32'(bus.prod_data), 0);
        chk("midrst_err", 32'(bus.err), 0);
        tick();
        rst = 1'b0;
        tick();
        send_beat(14'h3800, 1'b1, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd8188, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("postrst_prod_data", 32'(bus.prod_data), 4190209);
        chk("postrst_err", 32'(bus.err), 0);
        tick();

        // Negative final sum (-2) flags overflow; low 22 bits are 0x3FFFFE
        send_beat(14'h3FFE, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b0);
        send_beat(14'd0, 1'b0, 1'b1);
        bus.pp_valid = 1'b0;
        chk("neg_prod_data", 32'(bus.prod_data), 4194302);
        chk("neg_err", 32'(bus.err), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
